// File: rtl/color_pkg.sv
// Shared types and constants for the palette pixel pipe.
// Covers the pipeline defaults, colour levels, drain FSM states and write-queue entry layout.
package color_pkg;

    localparam int PIPE_LAT_DEF = 3;
    localparam int WQ_DEPTH_DEF = 4;

    localparam logic [7:0] LVL_FULL = 8'hFF;
    localparam logic [7:0] LVL_DIM  = 8'hC0;
    localparam logic [7:0] LVL_OFF  = 8'h00;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_st_t;

    typedef struct packed {
        logic [3:0] addr;
        logic [3:0] data;
    } wq_entry_t;

    // Palette bits are active-low; bit3 selects the dimmer lit level.
    function automatic logic [7:0] chan_level(input logic lit_n, input logic dim);
        if (lit_n) begin
            return LVL_OFF;
        end else if (dim) begin
            return LVL_DIM;
        end else begin
            return LVL_FULL;
        end
    endfunction

endpackage

// File: rtl/color_wq.sv
// Deferred palette-write FIFO with occupancy count, full flag and sticky overflow.
// Only instantiated when VBLANK_WRITE_EN is defined.
module color_wq
    import color_pkg::*;
#(
    parameter int DEPTH = WQ_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  wq_entry_t                i_entry,
    input  logic                     i_pop,
    output wq_entry_t                o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wq_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_full;
    logic            r_ovf;
    logic            w_do_push;
    logic            w_do_pop;

    // A push into a full queue is dropped even if a pop happens in the same clk.
    assign w_do_push = i_push && (r_count != CW'(DEPTH));
    assign w_do_pop  = i_pop && (r_count != {CW{1'b0}});

    // Next occupancy; push+pop together leaves it unchanged.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage, pointers, count and status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= wq_entry_t'(8'h00);
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_entry;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (i_push && !w_do_push) begin
                r_ovf <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_full;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/color_pixel_pipe.sv
// Palette-indexed pixel pipeline (3-clk latency) with a CPU write port into the colour RAM.
// Define VBLANK_WRITE_EN to defer CPU writes into color_wq and drain them during vertical blank.
module color_pixel_pipe
    import color_pkg::*;
#(
    parameter int PIPE_LAT = PIPE_LAT_DEF,
    parameter int WQ_DEPTH = WQ_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cpu_addr,
    input  logic [3:0] cpu_din,
    input  logic       cpu_we_n,
    output logic [3:0] cpu_dout,
    output logic       cpu_busy,
    output logic       wq_ovf,
    output logic [3:0] ram_addr_a,
    output logic [3:0] ram_din_a,
    output logic       ram_we_n_a,
    input  logic [3:0] ram_dout_a,
    output logic [3:0] ram_addr_b,
    input  logic [3:0] ram_dout_b,
    input  logic [3:0] pix_idx,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       blank_in,
    input  logic       vblank_in,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       hsync,
    output logic       vsync,
    output logic       blank
);
    if (PIPE_LAT != 3) begin : g_lat_chk
        $error("color_pixel_pipe: only PIPE_LAT=3 is supported");
    end
    if (WQ_DEPTH < 2 || (WQ_DEPTH & (WQ_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("color_pixel_pipe: WQ_DEPTH must be a power of two >= 2");
    end

    logic [3:0] r_addr_b;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;
    logic [2:0] r_sync_sr [PIPE_LAT];
    logic       r_we_n_prev;
    logic       r_we_n_a;
    logic [3:0] r_addr_a;
    logic [3:0] r_din_a;
    logic       w_wr_det;

    // Video path: index register, then decode of RAM data; timing rides a shift register alongside.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr_b <= 4'h0;
            r_r      <= 8'h00;
            r_g      <= 8'h00;
            r_b      <= 8'h00;
            for (int i = 0; i < PIPE_LAT; i++) begin
                r_sync_sr[i] <= 3'b000;
            end
        end else begin
            r_addr_b     <= pix_idx;
            r_sync_sr[0] <= {hsync_in, vsync_in, blank_in};
            for (int i = 1; i < PIPE_LAT; i++) begin
                r_sync_sr[i] <= r_sync_sr[i-1];
            end
            // Blank is taken from the stage that lands on the outputs together with this colour.
            if (r_sync_sr[PIPE_LAT-2][0]) begin
                r_r <= LVL_OFF;
                r_g <= LVL_OFF;
                r_b <= LVL_OFF;
            end else begin
                r_r <= chan_level(ram_dout_b[2], ram_dout_b[3]);
                r_g <= chan_level(ram_dout_b[1], ram_dout_b[3]);
                r_b <= chan_level(ram_dout_b[0], ram_dout_b[3]);
            end
        end
    end

    // Previous cpu_we_n, for falling-edge write detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we_n_prev <= 1'b1;
        end else begin
            r_we_n_prev <= cpu_we_n;
        end
    end

    assign w_wr_det = r_we_n_prev && !cpu_we_n;

`ifdef VBLANK_WRITE_EN
    localparam int CW = $clog2(WQ_DEPTH) + 1;

    drain_st_t     r_state;
    drain_st_t     w_state_nxt;
    logic          w_pop;
    wq_entry_t     w_push_entry;
    wq_entry_t     w_q_head;
    logic [CW-1:0] w_q_count;
    logic          w_q_full;
    logic          w_q_ovf;

    assign w_push_entry = {cpu_addr, cpu_din};

    color_wq #(
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_wr_det),
        .i_entry (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_q_head),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_ovf   (w_q_ovf)
    );

    // Drain state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain next-state and pop: one entry per clk while vblank holds and entries remain.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (vblank_in && (w_q_count != {CW{1'b0}})) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (vblank_in && (w_q_count != {CW{1'b0}})) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Port A: queue head while popping, otherwise tracks the CPU address for readback.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we_n_a <= 1'b1;
            r_addr_a <= 4'h0;
            r_din_a  <= 4'h0;
        end else begin
            r_we_n_a <= !w_pop;
            if (w_pop) begin
                r_addr_a <= w_q_head.addr;
                r_din_a  <= w_q_head.data;
            end else begin
                r_addr_a <= cpu_addr;
                r_din_a  <= cpu_din;
            end
        end
    end

    assign cpu_busy = w_q_full;
    assign wq_ovf   = w_q_ovf;
`else
    logic w_unused_vblank;
    assign w_unused_vblank = vblank_in;

    // Port A: a detected write becomes a single-clk write strobe with the captured address/data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_we_n_a <= 1'b1;
            r_addr_a <= 4'h0;
            r_din_a  <= 4'h0;
        end else begin
            r_we_n_a <= !w_wr_det;
            r_addr_a <= cpu_addr;
            r_din_a  <= cpu_din;
        end
    end

    assign cpu_busy = 1'b0;
    assign wq_ovf   = 1'b0;
`endif

    assign ram_addr_b = r_addr_b;
    assign ram_addr_a = r_addr_a;
    assign ram_din_a  = r_din_a;
    assign ram_we_n_a = r_we_n_a;
    assign cpu_dout   = ram_dout_a;
    assign r          = r_r;
    assign g          = r_g;
    assign b          = r_b;
    assign hsync      = r_sync_sr[PIPE_LAT-1][2];
    assign vsync      = r_sync_sr[PIPE_LAT-1][1];
    assign blank      = r_sync_sr[PIPE_LAT-1][0];

endmodule

// File: tb/tb_color_pixel_pipe.sv
// Directed bench for color_pixel_pipe with a behavioural dual-port colour RAM.
// Queue scenarios are exercised when VBLANK_WRITE_EN is defined.
module tb_color_pixel_pipe;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] cpu_addr, cpu_din;
    logic       cpu_we_n;
    logic [3:0] cpu_dout;
    logic       cpu_busy, wq_ovf;
    logic [3:0] ram_addr_a, ram_din_a, ram_dout_a;
    logic       ram_we_n_a;
    logic [3:0] ram_addr_b, ram_dout_b;
    logic [3:0] pix_idx;
    logic       hsync_in, vsync_in, blank_in, vblank_in;
    logic [7:0] r, g, b;
    logic       hsync, vsync, blank;

    int checks = 0;
    int errors = 0;

    logic [3:0] mem [16] = '{4'hF, 4'hF, 4'hF, 4'h9, 4'hF, 4'h2, 4'hF, 4'h0,
                             4'hF, 4'hE, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

    color_pixel_pipe dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_we_n   (cpu_we_n),
        .cpu_dout   (cpu_dout),
        .cpu_busy   (cpu_busy),
        .wq_ovf     (wq_ovf),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_we_n_a (ram_we_n_a),
        .ram_dout_a (ram_dout_a),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b),
        .pix_idx    (pix_idx),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .blank_in   (blank_in),
        .vblank_in  (vblank_in),
        .r          (r),
        .g          (g),
        .b          (b),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank      (blank)
    );

    always #5 clk = ~clk;

    // Registered-read colour RAM; port A writes land on the clk where ram_we_n_a is low.
    always @(posedge clk) begin
        if (!ram_we_n_a) mem[ram_addr_a] <= ram_din_a;
        ram_dout_a <= mem[ram_addr_a];
        ram_dout_b <= mem[ram_addr_b];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-clk video vector, then neutral inputs; outputs sampled 3 clks after capture.
    task automatic video(input string tag, input logic [3:0] idx, input logic h, input logic v,
                         input logic bl, input logic [26:0] exp);
        @(negedge clk);
        pix_idx = idx; hsync_in = h; vsync_in = v; blank_in = bl;
        @(negedge clk);
        pix_idx = 4'h0; hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(tag, {5'b0, r, g, b, hsync, vsync, blank}, {5'b0, exp});
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [3:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_din = d; cpu_we_n = 1'b0;
        @(negedge clk);
        cpu_we_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        cpu_addr = 4'h0; cpu_din = 4'h0; cpu_we_n = 1'b1;
        pix_idx = 4'h5; hsync_in = 1'b1; vsync_in = 1'b1; blank_in = 1'b1; vblank_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_video", {5'b0, r, g, b, hsync, vsync, blank}, 32'h0);
        check("rst_porta", {27'b0, ram_we_n_a, ram_addr_b}, {27'b0, 1'b1, 4'h0});
        check("rst_flags", {30'b0, cpu_busy, wq_ovf}, 32'h0);
        pix_idx = 4'h0; hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        @(negedge clk);
        pix_idx = 4'hC;
        @(negedge clk);
        check("addr_b_stage0", {28'b0, ram_addr_b}, {28'b0, 4'hC});
        pix_idx = 4'h0;
        repeat (3) @(negedge clk);

        video("pix5_bright_rb", 4'h5, 1'b1, 1'b0, 1'b0, {8'hFF, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0});
        video("pix3_dim_rg",    4'h3, 1'b0, 1'b1, 1'b0, {8'hC0, 8'hC0, 8'h00, 1'b0, 1'b1, 1'b0});
        video("pix7_blanked",   4'h7, 1'b1, 1'b1, 1'b1, {8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1});
        video("pix7_white",     4'h7, 1'b0, 1'b0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0});
        video("pix9_dim_b",     4'h9, 1'b0, 1'b0, 1'b0, {8'h00, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b0});

`ifndef VBLANK_WRITE_EN
        @(negedge clk);
        cpu_addr = 4'hA; cpu_din = 4'h3; cpu_we_n = 1'b0;
        @(negedge clk);
        check("direct_write", {23'b0, ram_we_n_a, ram_addr_a, ram_din_a}, {23'b0, 1'b0, 4'hA, 4'h3});
        @(negedge clk);
        check("write_one_clk", {31'b0, ram_we_n_a}, 32'h1);
        @(negedge clk);
        check("held_low_no_rewrite", {31'b0, ram_we_n_a}, 32'h1);
        check("readback", {28'b0, cpu_dout}, {28'b0, 4'h3});
        cpu_we_n = 1'b1;
        check("flags_const", {30'b0, cpu_busy, wq_ovf}, 32'h0);
        video("pixA_written", 4'hA, 1'b0, 1'b0, 1'b0, {8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
`else
        vblank_in = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cpu_write(4'(i), 4'(i));
            check("no_write_outside_vblank", {31'b0, ram_we_n_a}, 32'h1);
            if (i == 3) check("busy_after_3", {31'b0, cpu_busy}, 32'h0);
            if (i == 4) check("busy_after_4", {30'b0, cpu_busy, wq_ovf}, 32'h2);
            if (i == 5) check("ovf_after_5", {30'b0, cpu_busy, wq_ovf}, 32'h3);
        end
        vblank_in = 1'b1;
        @(negedge clk);
        check("drain_enter_no_write", {31'b0, ram_we_n_a}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("drain_order", {23'b0, ram_we_n_a, ram_addr_a, ram_din_a}, {23'b0, 1'b0, 4'(i), 4'(i)});
        end
        @(negedge clk);
        check("drain_done", {30'b0, ram_we_n_a, cpu_busy}, 32'h2);
        vblank_in = 1'b0;
        @(negedge clk);
        check("dropped_entry", {28'b0, mem[5]}, {28'b0, 4'h2});

        cpu_write(4'hB, 4'h6);
        cpu_write(4'hC, 4'h7);
        cpu_write(4'hD, 4'h8);
        vblank_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("part_pop1", {23'b0, ram_we_n_a, ram_addr_a, ram_din_a}, {23'b0, 1'b0, 4'hB, 4'h6});
        @(negedge clk);
        check("part_pop2", {23'b0, ram_we_n_a, ram_addr_a, ram_din_a}, {23'b0, 1'b0, 4'hC, 4'h7});
        vblank_in = 1'b0;
        @(negedge clk);
        check("vblank_fall_stops", {31'b0, ram_we_n_a}, 32'h1);
        repeat (2) @(negedge clk);
        check("held_outside_vblank", {31'b0, ram_we_n_a}, 32'h1);
        vblank_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("remaining_pop", {23'b0, ram_we_n_a, ram_addr_a, ram_din_a}, {23'b0, 1'b0, 4'hD, 4'h8});
        @(negedge clk);
        check("remaining_done", {31'b0, ram_we_n_a}, 32'h1);
        vblank_in = 1'b0;

        cpu_write(4'h2, 4'hA);
        cpu_write(4'h3, 4'hB);
        vblank_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_pop", {23'b0, ram_we_n_a, ram_addr_a, ram_din_a}, {23'b0, 1'b0, 4'h2, 4'hA});
        reset_n = 1'b0;
        #1;
        check("async_reset_we", {31'b0, ram_we_n_a}, 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_write_after_reset", {31'b0, ram_we_n_a}, 32'h1);
        end
        check("flags_after_reset", {30'b0, cpu_busy, wq_ovf}, 32'h0);
        vblank_in = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
